// File: rtl/config_ctrl_fsm.sv
// Clock-setting controller: steps through hours/minutes/seconds edit fields from
// debounced buttons, issues up/down pulses, and hands the result to the RTC writer.
module config_ctrl_fsm #(
  parameter int                CNT_W       = 24,
  parameter logic [CNT_W-1:0]  TIMEOUT_CYC = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_cfg,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_right,
  input  logic       btn_left,
  input  logic       write_ack,
  output logic [3:0] en_count,
  output logic       enUP,
  output logic       enDOWN,
  output logic       edit_mode,
  output logic       write_req,
  output logic       abort
);

  // state  | meaning
  // IDLE   | clock running, buttons other than cfg ignored
  // EDIT   | one field selected, up/down adjust it, cfg commits
  // COMMIT | write_req held until the RTC acknowledges
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EDIT   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam logic [1:0] F_HRS = 2'd0;
  localparam logic [1:0] F_SEC = 2'd2;
  localparam logic [1:0] F_BAD = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_CYC - CNT_W'(1);

  localparam int B_CFG   = 0;
  localparam int B_UP    = 1;
  localparam int B_DOWN  = 2;
  localparam int B_RIGHT = 3;
  localparam int B_LEFT  = 4;

  logic [4:0]       btn_live;
  logic [4:0]       btn_prev_q;
  logic [4:0]       rise;

  logic [1:0]       state_q,    state_d;
  logic [1:0]       field_q,    field_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [3:0]       en_count_q, en_count_d;
  logic             up_q,       up_d;
  logic             down_q,     down_d;
  logic             edit_q,     edit_d;
  logic             wreq_q,     wreq_d;
  logic             abort_q,    abort_d;

  assign btn_live = {btn_left, btn_right, btn_down, btn_up, btn_cfg};
  assign rise     = btn_live & ~btn_prev_q;

  // Loaded even while reset is asserted, so a button held across reset release is not an edge.
  always_ff @(posedge clk) begin
    btn_prev_q <= btn_live;
  end

  always_comb begin
    state_d = state_q;
    field_d = field_q;
    cnt_d   = '0;
    up_d    = 1'b0;
    down_d  = 1'b0;
    abort_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        field_d = F_HRS;
        if (rise[B_CFG]) begin
          state_d = S_EDIT;
        end
      end

      S_EDIT: begin
        if (rise[B_CFG]) begin
          state_d = S_COMMIT;
        end else if (rise[B_UP]) begin
          up_d = 1'b1;
        end else if (rise[B_DOWN]) begin
          down_d = 1'b1;
        end else if (rise[B_RIGHT]) begin
          field_d = (field_q == F_SEC) ? F_HRS : field_q + 2'd1;
        end else if (rise[B_LEFT]) begin
          field_d = (field_q == F_HRS) ? F_SEC : field_q - 2'd1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          field_d = F_HRS;
          abort_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_COMMIT: begin
        if (write_ack) begin
          state_d = S_IDLE;
          field_d = F_HRS;
        end
      end

      default: begin
        state_d = S_IDLE;
        field_d = F_HRS;
      end
    endcase

    // An out-of-range field is treated like a corrupted state: recover to IDLE.
    if (field_q == F_BAD) begin
      state_d = S_IDLE;
      field_d = F_HRS;
      cnt_d   = '0;
      up_d    = 1'b0;
      down_d  = 1'b0;
      abort_d = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they land one cycle after the edge.
  always_comb begin
    case (state_d)
      S_EDIT:   en_count_d = {2'b00, field_d} + 4'd1;
      S_COMMIT: en_count_d = 4'd4;
      default:  en_count_d = 4'd0;
    endcase
    edit_d = (state_d == S_EDIT) || (state_d == S_COMMIT);
    wreq_d = (state_d == S_COMMIT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      field_q    <= F_HRS;
      cnt_q      <= '0;
      en_count_q <= 4'd0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      edit_q     <= 1'b0;
      wreq_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      field_q    <= field_d;
      cnt_q      <= cnt_d;
      en_count_q <= en_count_d;
      up_q       <= up_d;
      down_q     <= down_d;
      edit_q     <= edit_d;
      wreq_q     <= wreq_d;
      abort_q    <= abort_d;
    end
  end

  assign en_count  = en_count_q;
  assign enUP      = up_q;
  assign enDOWN    = down_q;
  assign edit_mode = edit_q;
  assign write_req = wreq_q;
  assign abort     = abort_q;

endmodule

// File: tb/tb_config_ctrl_fsm.sv
// Bench for config_ctrl_fsm: directed scenarios then random button traffic,
// every cycle compared against a behavioural model of the edit/commit rules.
module tb_config_ctrl_fsm;

  localparam int T_CYC = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_cfg = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic       btn_right = 1'b0, btn_left = 1'b0, write_ack = 1'b0;
  logic [3:0] en_count;
  logic       enUP, enDOWN, edit_mode, write_req, abort;

  int vectors = 0;
  int miscompares = 0;

  // Model: mode 0 run, 1 editing, 2 committing; field 0..2; quiet = cycles without an edge.
  int         m_mode = 0;
  int         m_field = 0;
  int         m_quiet = 0;
  logic [4:0] m_prev = 5'b0;
  logic [8:0] m_out = 9'b0;

  config_ctrl_fsm #(.CNT_W(24), .TIMEOUT_CYC(24'd8)) dut (
    .clk(clk), .reset(reset),
    .btn_cfg(btn_cfg), .btn_up(btn_up), .btn_down(btn_down),
    .btn_right(btn_right), .btn_left(btn_left), .write_ack(write_ack),
    .en_count(en_count), .enUP(enUP), .enDOWN(enDOWN),
    .edit_mode(edit_mode), .write_req(write_req), .abort(abort)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [4:0] lvl, rise;
    int win, ec;
    logic up, dn, ab;
    lvl = {btn_left, btn_right, btn_down, btn_up, btn_cfg};
    rise = lvl & ~m_prev;
    m_prev = lvl;
    up = 1'b0; dn = 1'b0; ab = 1'b0;
    if (!reset) begin
      m_mode = 0; m_field = 0; m_quiet = 0;
    end else if (m_mode == 0) begin
      if (rise[0]) begin m_mode = 1; m_field = 0; m_quiet = 0; end
    end else if (m_mode == 1) begin
      win = -1;
      for (int i = 0; i < 5; i++) if (win < 0 && rise[i]) win = i;
      case (win)
        0: m_mode = 2;
        1: up = 1'b1;
        2: dn = 1'b1;
        3: m_field = (m_field + 1) % 3;
        4: m_field = (m_field + 2) % 3;
        default: begin
          if (m_quiet == T_CYC - 1) begin
            m_mode = 0; m_field = 0; ab = 1'b1;
          end
        end
      endcase
      m_quiet = (win >= 0 || ab) ? 0 : m_quiet + 1;
    end else begin
      if (write_ack) begin m_mode = 0; m_field = 0; end
    end
    ec = (m_mode == 1) ? m_field + 1 : (m_mode == 2) ? 4 : 0;
    m_out = {ec[3:0], up, dn, (m_mode != 0), (m_mode == 2), ab};
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check(tag, {23'b0, en_count, enUP, enDOWN, edit_mode, write_req, abort}, {23'b0, m_out});
    check("up_down_exclusive", {31'b0, enUP & enDOWN}, 32'd0);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    int pulses;
    int rate;

    // Reset with cfg held, release: no edge may be seen.
    reset = 1'b0; btn_cfg = 1'b1;
    ticks(3, "reset");
    check("reset_state", {24'b0, en_count, edit_mode, write_req, abort, enUP}, 32'd0);
    reset = 1'b1;
    tick("held_cfg");
    check("held_cfg_no_edge", {31'b0, edit_mode}, 32'd0);
    btn_cfg = 1'b0; tick("cfg_low");
    btn_cfg = 1'b1; tick("enter_edit");
    check("enter_edit_mode", {31'b0, edit_mode}, 32'd1);
    check("enter_edit_field", {28'b0, en_count}, 32'd1);
    btn_cfg = 1'b0; tick("edit");

    // Field navigation with wrap.
    btn_right = 1'b1; tick("right1"); check("right1_field", {28'b0, en_count}, 32'd2);
    btn_right = 1'b0; tick("edit");
    btn_right = 1'b1; tick("right2"); check("right2_field", {28'b0, en_count}, 32'd3);
    btn_right = 1'b0; tick("edit");
    btn_right = 1'b1; tick("right3"); check("right3_wrap", {28'b0, en_count}, 32'd1);
    btn_right = 1'b0; tick("edit");
    btn_left = 1'b1;  tick("left1");  check("left_wrap", {28'b0, en_count}, 32'd3);
    btn_left = 1'b0;  tick("edit");
    btn_left = 1'b1;  tick("left2");  check("left_to_min", {28'b0, en_count}, 32'd2);
    btn_left = 1'b0;  tick("edit");

    // Held up button: a single pulse.
    pulses = 0;
    btn_up = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick("up_held");
      pulses += int'(enUP);
      check("up_held_field", {28'b0, en_count}, 32'd2);
    end
    check("up_held_pulses", pulses, 32'd1);
    btn_up = 1'b0; tick("edit");

    // Simultaneous up and down: up wins.
    btn_up = 1'b1; btn_down = 1'b1; tick("up_down");
    check("up_down_up", {31'b0, enUP}, 32'd1);
    check("up_down_down", {31'b0, enDOWN}, 32'd0);
    btn_up = 1'b0; btn_down = 1'b0; tick("edit");

    // Commit, ack after 7 cycles.
    btn_cfg = 1'b1; tick("commit");
    check("commit_field", {28'b0, en_count}, 32'd4);
    btn_cfg = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick("commit_wait");
      check("commit_wreq_held", {31'b0, write_req}, 32'd1);
    end
    write_ack = 1'b1; tick("ack");
    check("ack_wreq", {31'b0, write_req}, 32'd0);
    check("ack_field", {28'b0, en_count}, 32'd0);
    write_ack = 1'b0; tick("idle");

    // Timeout after T_CYC quiet cycles.
    btn_cfg = 1'b1; tick("enter_edit2");
    btn_cfg = 1'b0;
    ticks(T_CYC - 1, "quiet");
    check("no_early_abort", {31'b0, edit_mode}, 32'd1);
    tick("timeout");
    check("timeout_abort", {31'b0, abort}, 32'd1);
    check("timeout_field", {28'b0, en_count}, 32'd0);
    tick("after_timeout");
    check("abort_one_cycle", {30'b0, abort, write_req}, 32'd0);

    // Edge in the timeout cycle keeps EDIT.
    btn_cfg = 1'b1; tick("enter_edit3");
    btn_cfg = 1'b0;
    ticks(T_CYC - 1, "quiet");
    btn_up = 1'b1; tick("edge_at_timeout");
    check("edge_wins_abort", {30'b0, abort, edit_mode}, 32'd1);
    btn_up = 1'b0;
    ticks(T_CYC - 1, "quiet_after_clear");
    check("counter_cleared", {31'b0, edit_mode}, 32'd1);

    // Reset mid-commit.
    btn_cfg = 1'b1; tick("commit2");
    btn_cfg = 1'b0; tick("commit_wait");
    reset = 1'b0; tick("reset_commit");
    check("reset_commit_wreq", {31'b0, write_req}, 32'd0);
    reset = 1'b1; tick("idle");
    write_ack = 1'b1; tick("stray_ack");
    check("stray_ack_idle", {31'b0, edit_mode}, 32'd0);
    write_ack = 1'b0;

    // Random traffic with varying activity.
    rate = 8;
    for (int n = 0; n < 4000; n++) begin
      if (n % 100 == 0) rate = $urandom_range(3, 40);
      if ($urandom_range(0, rate * 2 - 1) == 0) btn_cfg   = ~btn_cfg;
      if ($urandom_range(0, rate - 1) == 0)     btn_up    = ~btn_up;
      if ($urandom_range(0, rate - 1) == 0)     btn_down  = ~btn_down;
      if ($urandom_range(0, rate - 1) == 0)     btn_right = ~btn_right;
      if ($urandom_range(0, rate - 1) == 0)     btn_left  = ~btn_left;
      write_ack = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 299) != 0);
      tick("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/config_ctrl_fsm.md
CONFIG_CTRL_FSM -- requirements
Module: config_ctrl_fsm

Interface
REQ-001 Parameter: TIMEOUT_CYC, 24'd10_000_000, edit-mode inactivity limit in clk cycles.
REQ-002 Parameter: CNT_W, 24, width of the inactivity counter.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; one clock, synchronous reset, active-low.
REQ-005 btn_cfg  input  1  debounced level; enter edit, or commit edit.
REQ-006 btn_up  input  1  debounced level; increment the selected field.
REQ-007 btn_down  input  1  debounced level; decrement the selected field.
REQ-008 btn_right  input  1  debounced level; select the next field.
REQ-009 btn_left  input  1  debounced level; select the previous field.
REQ-010 write_ack  input  1  RTC write interface done strobe, 1 cycle.
REQ-011 en_count  output  4  field code: 0 run, 1 hours edit, 2 minutes edit, 3 seconds edit, 4 commit.
REQ-012 enUP  output  1  1-cycle increment pulse to the counter addressed by en_count.
REQ-013 enDOWN  output  1  1-cycle decrement pulse to the counter addressed by en_count.
REQ-014 edit_mode  output  1  high in EDIT and COMMIT.
REQ-015 write_req  output  1  held high in COMMIT until write_ack.
REQ-016 abort  output  1  1-cycle pulse on timeout exit.

Function
REQ-017 Edge detect: a rising edge is btn=1 with a registered previous value of 0; the previous-value registers load the live inputs while reset=0, so buttons held through reset release produce no edge.
REQ-018 All outputs are registered; a response appears in the cycle after the edge is detected (latency 1).
REQ-019 States: IDLE, EDIT, COMMIT; 2-bit field register F in {0,1,2}, meaning hours, minutes, seconds.
REQ-020 IDLE: en_count=0, enUP/enDOWN=0, write_req=0; a btn_cfg edge -> EDIT with F=0.
REQ-021 EDIT: en_count=F+1.
REQ-022 EDIT: a btn_up edge pulses enUP for 1 cycle.
REQ-023 EDIT: a btn_down edge pulses enDOWN for 1 cycle.
REQ-024 EDIT: a btn_right edge sets F=(F==2)?0:F+1.
REQ-025 EDIT: a btn_left edge sets F=(F==0)?2:F-1.
REQ-026 EDIT: a btn_cfg edge -> COMMIT.
REQ-027 Same-cycle edge priority: cfg > up > down > right > left; only the winner acts and the others are discarded.
REQ-028 enUP and enDOWN are never high in the same cycle.
REQ-029 COMMIT: en_count=4, write_req=1.
REQ-030 COMMIT: write_ack -> IDLE next cycle with write_req=0 and F=0.
REQ-031 COMMIT: button edges are ignored.
REQ-032 Inactivity counter clears on entry to EDIT and on any accepted edge, otherwise increments in EDIT.
REQ-033 Inactivity counter == TIMEOUT_CYC-1 with no edge -> IDLE, abort pulsed 1 cycle, no write_req.
REQ-034 An edge arriving in the timeout cycle wins over the timeout and clears the counter.
REQ-035 Inactivity counter holds at 0 outside EDIT.
REQ-036 write_ack outside COMMIT is ignored.
REQ-037 Illegal state or F=3 -> IDLE, F=0 on the next cycle.

Reset
REQ-038 reset=0 at a clk edge: state=IDLE, F=0, counter=0, en_count=0, enUP=enDOWN=write_req=abort=0, edit_mode=0.
REQ-039 Reset mid-COMMIT drops write_req the next cycle; no write completes.
REQ-040 Reset overrides every other input.

Verification
REQ-041 Reset release, then btn_cfg 0->1 -> next cycle edit_mode=1, en_count=1.
REQ-042 In EDIT, F=0: right, right, right edges, then left edge -> en_count 2, 3, 1, then 3.
REQ-043 In EDIT, F=1: btn_up held high 5 cycles -> exactly one enUP pulse, en_count=2 throughout.
REQ-044 In EDIT: btn_up and btn_down rise same cycle -> enUP=1, enDOWN=0.
REQ-045 In EDIT: btn_cfg edge -> en_count=4, write_req=1 held; write_ack after 7 cycles -> next cycle write_req=0, en_count=0.
REQ-046 TIMEOUT_CYC=8, in EDIT, no input for 8 cycles -> abort pulse, en_count=0, write_req never asserted; repeat with an edge in cycle 8 -> stays in EDIT.
